// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler:
// message identifiers, FSM states, message lengths, the banner string
// and small helpers for digit encoding and message length lookup.
package enum_type;

   typedef enum logic [1:0] {
      MSG_NONE  = 2'd0,
      MSG_SCORE = 2'd1,
      MSG_OVER  = 2'd2,
      MSG_ECHO  = 2'd3
   } msg_type;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_GAP
   } state_type;

   localparam int SCORE_LEN = 8;   // "S:" + 4 digits + CR LF
   localparam int OVER_LEN  = 11;  // "GAME OVER" + CR LF
   localparam int ECHO_LEN  = 1;

   // First character sits in the most significant byte.
   localparam logic [8*OVER_LEN-1:0] OVER_STR = {"GAME OVER", 8'h0D, 8'h0A};

   // ASCII digit for a BCD nibble; invalid nibbles show as '?'.
   function automatic logic [7:0] bcd_char(input logic [3:0] nib);
      return (nib > 4'd9) ? 8'h3F : (8'h30 + {4'h0, nib});
   endfunction

   // Index of the final byte of a message.
   function automatic logic [3:0] last_index(input msg_type msg);
      case (msg)
         MSG_SCORE: return 4'(SCORE_LEN - 1);
         MSG_OVER:  return 4'(OVER_LEN - 1);
         MSG_ECHO:  return 4'(ECHO_LEN - 1);
         default:   return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rom.sv
// Message content lookup: turns (message, byte index, score snapshot,
// echo byte) into the byte to transmit, so the scheduler FSM carries
// no string data of its own.
module tx_msg_rom
   import enum_type::*;
(
   input  msg_type     msg,
   input  logic [3:0]  index,
   input  logic [15:0] score,
   input  logic [7:0]  echo,
   output logic [7:0]  data
);

   logic [3:0] rev;

   // Select the byte for the current message position.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      data = 8'h00;
      rev  = 4'(OVER_LEN - 1) - index;
      case (msg)
         MSG_SCORE: begin
            case (index)
               4'd0:    data = 8'h53;               // 'S'
               4'd1:    data = 8'h3A;               // ':'
               4'd2:    data = bcd_char(score[15:12]);
               4'd3:    data = bcd_char(score[11:8]);
               4'd4:    data = bcd_char(score[7:4]);
               4'd5:    data = bcd_char(score[3:0]);
               4'd6:    data = 8'h0D;
               4'd7:    data = 8'h0A;
               default: data = 8'h00;
            endcase
         end
         MSG_OVER: begin
            if (index <= last_index(MSG_OVER))
               data = OVER_STR[{rev, 3'b000} +: 8];
         end
         MSG_ECHO: data = echo;
         default:  data = 8'h00;
      endcase
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among the score report, the game-over
// banner and the key echo. Requests latch into pending flags, are
// granted round-robin and sent byte by byte with a fixed gap.
// Build option: define TX_ECHO_EN to let the echo requester take part;
// without it req_echo/echo_byte are ignored.
module uart_tx_scheduler
   import enum_type::*;
#(
   parameter int GAP_TICK     = 16,
   parameter int BUSY_TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] score,
   input  logic        req_score,
   input  logic        req_over,
   input  logic        req_echo,
   input  logic [7:0]  echo_byte,
   input  logic        is_transmitting,
   output logic        transmit,
   output logic [7:0]  tx_byte,
   output logic        busy,
   output msg_type     grant
);

   localparam logic [7:0] GAP_LAST  = 8'(GAP_TICK - 1);
   localparam logic [7:0] BUSY_LAST = 8'(BUSY_TIMEOUT - 1);

   state_type   state;
   msg_type     rr_ptr;
   msg_type     pick;
   logic        pend_score;
   logic        pend_over;
   logic        pend_echo;
   logic        pend_any;
   logic        load_now;
   logic [3:0]  index;
   logic [7:0]  cnt;
   logic [15:0] score_snap;
   logic [7:0]  echo_latch;
   logic [7:0]  echo_snap;
   logic [7:0]  rom_data;

   // Pointer successor; echo is skipped when it cannot participate.
   function automatic msg_type rr_next(input msg_type m);
      case (m)
         MSG_SCORE: return MSG_OVER;
`ifdef TX_ECHO_EN
         MSG_OVER:  return MSG_ECHO;
`else
         MSG_OVER:  return MSG_SCORE;
`endif
         default:   return MSG_SCORE;
      endcase
   endfunction

   assign pend_any = pend_score | pend_over | pend_echo;
   assign load_now = (state == ST_LOAD);

   // Pending flags: a new request in the grant cycle wins over the clear.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state is written with <= so every flop samples pre-edge values.
      if (!reset_n) begin
         pend_score <= 1'b0;
         pend_over  <= 1'b0;
      end else begin
         pend_score <= (pend_score & ~(load_now && pick == MSG_SCORE)) | req_score;
         pend_over  <= (pend_over  & ~(load_now && pick == MSG_OVER))  | req_over;
      end
   end

`ifdef TX_ECHO_EN
   // Echo flag and byte: the latest echo request overwrites the byte.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_echo  <= 1'b0;
         echo_latch <= 8'h00;
      end else begin
         pend_echo <= (pend_echo & ~(load_now && pick == MSG_ECHO)) | req_echo;
         if (req_echo)
            echo_latch <= echo_byte;
      end
   end
`else
   logic unused_echo;
   assign pend_echo   = 1'b0;
   assign echo_latch  = 8'h00;
   assign unused_echo = ^{req_echo, echo_byte};
`endif

   // Round-robin search starting at the pointer.
   always_comb begin
      pick = MSG_NONE;
      case (rr_ptr)
         MSG_OVER: begin
            if      (pend_over)  pick = MSG_OVER;
            else if (pend_echo)  pick = MSG_ECHO;
            else if (pend_score) pick = MSG_SCORE;
         end
         MSG_ECHO: begin
            if      (pend_echo)  pick = MSG_ECHO;
            else if (pend_score) pick = MSG_SCORE;
            else if (pend_over)  pick = MSG_OVER;
         end
         default: begin
            if      (pend_score) pick = MSG_SCORE;
            else if (pend_over)  pick = MSG_OVER;
            else if (pend_echo)  pick = MSG_ECHO;
         end
      endcase
   end

   tx_msg_rom u_rom (
      .msg   (grant),
      .index (index),
      .score (score_snap),
      .echo  (echo_snap),
      .data  (rom_data)
   );

   // Message sequencer with registered strobe, byte, busy and grant.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         transmit   <= 1'b0;
         tx_byte    <= 8'h00;
         busy       <= 1'b0;
         grant      <= MSG_NONE;
         rr_ptr     <= MSG_SCORE;
         index      <= 4'd0;
         cnt        <= 8'd0;
         score_snap <= 16'h0000;
         echo_snap  <= 8'h00;
      end else begin
         transmit <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pend_any) begin
                  state <= ST_LOAD;
                  busy  <= 1'b1;
               end
            end
            ST_LOAD: begin
               grant      <= pick;
               rr_ptr     <= rr_next(pick);
               score_snap <= score;
               echo_snap  <= echo_latch;
               index      <= 4'd0;
               state      <= ST_SEND;
            end
            ST_SEND: begin
               transmit <= 1'b1;
               tx_byte  <= rom_data;
               cnt      <= 8'd0;
               state    <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (is_transmitting) begin
                  cnt   <= 8'd0;
                  state <= ST_WAIT_DONE;
               end else if (cnt == BUSY_LAST) begin
                  cnt   <= 8'd0;
                  state <= ST_GAP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_WAIT_DONE: begin
               if (!is_transmitting) begin
                  cnt   <= 8'd0;
                  state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt <= 8'd0;
                  if (index == last_index(grant)) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     grant <= MSG_NONE;
                  end else begin
                     index <= index + 4'd1;
                     state <= ST_SEND;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural UART model
// that records every strobed byte and the cycle it was strobed on.
module tb_uart_tx_scheduler;
   import enum_type::*;

   localparam int UART_T = 10;
   localparam int BUDGET = 3000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] score = 16'h0000;
   logic        req_score = 1'b0;
   logic        req_over = 1'b0;
   logic        req_echo = 1'b0;
   logic [7:0]  echo_byte = 8'h00;
   logic        is_transmitting;
   logic        transmit;
   logic [7:0]  tx_byte;
   logic        busy;
   msg_type     grant;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [7:0]  sent_q[$];
   logic [7:0]  exp_q[$];
   int          tx_cycle_q[$];
   int          cyc = 0;
   int          uart_cnt = 0;
   bit          uart_dead = 1'b0;
   bit          prev_tx = 1'b0;
   int          double_strobe = 0;
   int          busy_low_on_tx = 0;
   int          busy_seen = 0;

   always #5 clk = ~clk;

   uart_tx_scheduler dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .score           (score),
      .req_score       (req_score),
      .req_over        (req_over),
      .req_echo        (req_echo),
      .echo_byte       (echo_byte),
      .is_transmitting (is_transmitting),
      .transmit        (transmit),
      .tx_byte         (tx_byte),
      .busy            (busy),
      .grant           (grant)
   );

   // UART model: busy for UART_T cycles after each strobe unless dead.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         is_transmitting <= 1'b0;
         uart_cnt = 0;
         prev_tx  = 1'b0;
      end else begin
         cyc++;
         if (transmit) begin
            sent_q.push_back(tx_byte);
            tx_cycle_q.push_back(cyc);
            if (prev_tx) double_strobe++;
            if (!busy) busy_low_on_tx++;
            if (!uart_dead) begin
               is_transmitting <= 1'b1;
               uart_cnt = UART_T;
            end
         end else if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) is_transmitting <= 1'b0;
         end
         prev_tx = transmit;
      end
   end

   always @(negedge clk) if (busy) busy_seen++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req_score = 1'b0;
      req_over  = 1'b0;
      req_echo  = 1'b0;
      uart_dead = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      sent_q.delete();
      tx_cycle_q.delete();
      exp_q.delete();
      double_strobe  = 0;
      busy_low_on_tx = 0;
      busy_seen      = 0;
   endtask

   // which: 0 score, 1 over, 2 echo, 3 score+over together
   task automatic pulse(input int which, input logic [7:0] eb);
      @(negedge clk);
      case (which)
         0: req_score = 1'b1;
         1: req_over  = 1'b1;
         2: begin req_echo = 1'b1; echo_byte = eb; end
         default: begin req_score = 1'b1; req_over = 1'b1; end
      endcase
      @(negedge clk);
      req_score = 1'b0;
      req_over  = 1'b0;
      req_echo  = 1'b0;
   endtask

   task automatic wait_done(input int n, input string tag);
      int k = 0;
      while ((sent_q.size() < n || busy) && k < BUDGET) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_timeout"}, 32'(k < BUDGET), 32'd1);
      repeat (100) @(negedge clk);
   endtask

   task automatic check_seq(input string tag);
      check({tag, "_len"}, 32'(sent_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
         check($sformatf("%s_b%0d", tag, i), 32'(sent_q[i]), 32'(exp_q[i]));
   endtask

   task automatic push_bytes(input logic [63:0] v);
      for (int i = 7; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
   endtask

   task automatic push_over();
      string s = "GAME OVER";
      for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   initial begin
      int k;
      int n0;

      // Reset state
      do_reset();
      check("rst_transmit", 32'(transmit), 32'd0);
      check("rst_tx_byte", 32'(tx_byte), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_grant", 32'(grant), 32'(MSG_NONE));

      // Score report 0427
      score = 16'h0427;
      pulse(0, 8'h00);
      repeat (3) @(negedge clk);
      check("score_busy", 32'(busy), 32'd1);
      check("score_grant", 32'(grant), 32'(MSG_SCORE));
      wait_done(8, "score");
      push_bytes(64'h53_3A_30_34_32_37_0D_0A);
      check_seq("score");
      check("score_single_strobe", 32'(double_strobe), 32'd0);
      check("score_busy_on_tx", 32'(busy_low_on_tx), 32'd0);
      check("score_end_grant", 32'(grant), 32'(MSG_NONE));
      check("score_end_busy", 32'(busy), 32'd0);

      // Simultaneous over+score from reset pointer; also invalid nibble
      do_reset();
      score = 16'h9A05;
      pulse(3, 8'h00);
      wait_done(19, "both");
      push_bytes(64'h53_3A_39_3F_30_35_0D_0A);
      push_over();
      check_seq("both");
      check("both_single_strobe", 32'(double_strobe), 32'd0);

`ifdef TX_ECHO_EN
      // Two echoes during OVER coalesce; latest byte wins
      do_reset();
      pulse(1, 8'h00);
      repeat (20) @(negedge clk);
      pulse(2, 8'h61);
      repeat (20) @(negedge clk);
      pulse(2, 8'h62);
      wait_done(12, "echo");
      push_over();
      exp_q.push_back(8'h62);
      check_seq("echo");
`else
      // Echo requester ignored
      do_reset();
      pulse(2, 8'h61);
      repeat (300) @(negedge clk);
      check("noecho_sent", 32'(sent_q.size()), 32'd0);
      check("noecho_busy_seen", 32'(busy_seen), 32'd0);
`endif

      // Dead UART: each byte advances on the busy timeout
      do_reset();
      uart_dead = 1'b1;
      score = 16'h1234;
      pulse(0, 8'h00);
      wait_done(8, "dead");
      push_bytes(64'h53_3A_31_32_33_34_0D_0A);
      check_seq("dead");
      check("dead_period_first", 32'((tx_cycle_q.size() >= 2) ? tx_cycle_q[1] - tx_cycle_q[0] : -1), 32'd25);
      check("dead_period_last", 32'((tx_cycle_q.size() >= 8) ? tx_cycle_q[7] - tx_cycle_q[6] : -1), 32'd25);

      // Asynchronous reset during byte 3 of OVER, score pending
      do_reset();
      pulse(1, 8'h00);
      repeat (5) @(negedge clk);
      score = 16'h0001;
      pulse(0, 8'h00);
      k = 0;
      while (!(transmit && sent_q.size() == 2) && k < BUDGET) begin
         @(negedge clk);
         k++;
      end
      check("midrst_reach_byte3", 32'(k < BUDGET), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      check("midrst_transmit", 32'(transmit), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_grant", 32'(grant), 32'(MSG_NONE));
      #1 reset_n = 1'b1;
      n0 = sent_q.size();
      busy_seen = 0;
      repeat (400) @(negedge clk);
      check("midrst_no_bytes", 32'(sent_q.size()), 32'(n0));
      check("midrst_busy_seen", 32'(busy_seen), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares the single UART transmitter among three message requesters and sequences each message onto the transmitter byte by byte. The requesters are the score report, the game-over banner and the key echo. It sits beside the input controller: it drives the `transmit`/`tx_byte` pair of the `uart` instance and watches `is_transmitting`. Requests are latched as pending flags, granted round-robin, and serialised with a fixed inter-byte gap.

## Interface
- `GAP_TICK`, 16: idle cycles inserted after each byte completes, before the next byte or the next grant.
- `BUSY_TIMEOUT`, 8: max cycles to wait for `is_transmitting` to rise after a `transmit` pulse.
- `clk` in 1: system clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `score` in 16: four BCD digits; [15:12] is the most significant.
- `req_score` in 1: pulse; queue a score report.
- `req_over` in 1: pulse; queue the game-over banner.
- `req_echo` in 1: pulse; queue a one-byte echo of `echo_byte`.
- `echo_byte` in 8: byte to echo, sampled when `req_echo`=1.
- `is_transmitting` in 1: from the uart.
- `transmit` out 1: one-cycle strobe to the uart.
- `tx_byte` out 8: byte presented with `transmit`, held until the next strobe.
- `busy` out 1: a message is in progress (state ≠ IDLE).
- `grant` out 2 (`msg_type`): message currently sent; `MSG_NONE` when idle.

## Operation
- Reset values: `transmit`=0, `tx_byte`=0, `busy`=0, `grant`=`MSG_NONE`. All pending flags are 0, the round-robin pointer is `MSG_SCORE`, and the FSM is in IDLE.
- Pending flags:
  - `req_x`=1 sets `pend_x` on the next edge.
  - A repeated request while pending coalesces into one send.
  - `req_echo` overwrites the latched echo byte, so the latest byte wins.
- Messages:
  - SCORE: "S:" + 4 digits + CR LF, 8 bytes. Each digit is 8'h30+nibble; a nibble >9 is sent as "?" (8'h3F). `score` is snapshotted at grant.
  - OVER: "GAME OVER" CR LF, 11 bytes.
  - ECHO: 1 byte.
- Arbitration:
  - Round-robin order SCORE→OVER→ECHO.
  - The search starts at the pointer; after a grant the pointer moves to the entry following the granted one.
- FSM states:
  - IDLE: if any flag is pending, go to LOAD.
  - LOAD: latch `grant` and snapshot; clear the granted flag; byte index = 0. Go to SEND.
  - SEND: `transmit`=1 with `tx_byte` = message[index]. Go to WAIT_BUSY.
  - WAIT_BUSY:
    - `is_transmitting`=1 → WAIT_DONE.
    - Otherwise, after BUSY_TIMEOUT cycles → GAP (the byte is counted as sent).
  - WAIT_DONE: `is_transmitting`=0 → GAP.
  - GAP: count GAP_TICK cycles, then:
    - if index = last: go to IDLE and set `grant`=`MSG_NONE`;
    - else: index+1 and go to SEND.
- Boundaries:
  - A request for the message being granted in the same LOAD cycle: set wins, so the flag stays pending and the message is re-sent later.
  - Requests during a message are only latched; they never preempt it.
  - Asynchronous reset mid-message: immediately IDLE, `transmit`=0, all flags cleared. The partial message is abandoned.

## Timing
- From a request pulse at edge N, `pend` is set at N+1. LOAD follows at N+2 and the first `transmit` at N+3, provided the FSM was idle.
- With a uart that busies for T cycles, per-byte period = 1 (SEND) + 1..BUSY_TIMEOUT + T + GAP_TICK.
- Back-to-back pending messages are separated by one IDLE cycle plus LOAD.
- `transmit` is never high on two consecutive cycles.

## Configuration
- `TX_ECHO_EN` defined: the ECHO requester participates in arbitration.
- `TX_ECHO_EN` undefined:
  - `req_echo` and `echo_byte` are ignored; `pend_echo` is tied 0.
  - Round-robin covers SCORE and OVER only.
  - The ports remain present.

## Structure
- Shared package `enum_type`:
  - `msg_type` enum: `MSG_NONE`, `MSG_SCORE`, `MSG_OVER`, `MSG_ECHO`.
  - Message length constants.
  - The `GAME OVER` byte string constant.
- Sub-module `tx_msg_rom` (combinational): maps (`msg_type`, index, score snapshot, echo byte) to `tx_byte`, keeping the FSM free of string data.

## Test plan
- `score`=16'h0427, pulse `req_score`, with a uart model busy 10 cycles per byte → bytes 53 3A 30 34 32 37 0D 0A, each on a single-cycle `transmit`, with `busy` high throughout.
- `req_over` and `req_score` pulsed in the same cycle, pointer at reset → full SCORE message then full OVER message, with no interleaved bytes.
- `req_echo` "a" then "b" while OVER is in progress (`TX_ECHO_EN` on) → after OVER exactly one echo byte 8'h62.
- uart model never asserts `is_transmitting` → each byte advances after BUSY_TIMEOUT cycles; the message still completes in 8 bytes.
- `reset_n` low during byte 3 of OVER → `transmit`=0, `busy`=0 and `grant`=`MSG_NONE` with no clock edge. After release, no bytes are sent until a new request.
- Without `TX_ECHO_EN`, pulse `req_echo` → no `transmit` and `busy` stays 0.
